hls_axis_stall_detector: RTL
============================

Name: hls_axis_stall_detector

Overview:
- Upstream feeder of the HLS deadlock monitor. Watches the valid/ready pair of each AXI-stream channel on an HLS instance boundary.
- For each channel it produces a registered, thresholded "blocked" indication. This becomes the monitor's axis_block_sigs input.
- It filters out transient back-pressure, so only sustained stalls reach the deadlock monitor.

Parameters:
- NUM_CH, 1, number of monitored AXI-stream channels (1..32).
- CNT_W, 16, width of per-channel stall counters and the threshold input.
- ID_W, 1, width of first_block_id; must satisfy 2**ID_W >= NUM_CH.

Ports:
- clock  in  1  single design clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  detection enable; low forces all channels to IDLE.
- clear  in  1  synchronous clear of sticky diagnostics (first_block_*, event_count).
- thresh  in  CNT_W  stall-length threshold in cycles; 0 is treated as 1.
- tvalid  in  NUM_CH  per-channel TVALID.
- tready  in  NUM_CH  per-channel TREADY.
- rd_wait  in  NUM_CH  per-channel "consumer waiting for data" from the HLS instance.
- axis_block_sigs  out  NUM_CH  per-channel registered block flags.
- any_block  out  1  registered OR of all block flags.
- first_block_vld  out  1  sticky: some channel has entered BLOCKED since the last clear or reset.
- first_block_id  out  ID_W  index of the first channel to enter BLOCKED.
- event_count  out  16  block-event counter (optional feature).

Behaviour:
- Reset: every channel goes to IDLE with counter 0. All outputs are 0.
- Per-channel stall condition, evaluated each cycle: stall = (tvalid & ~tready) | (rd_wait & ~tvalid).
  - Full-side stall: tvalid & ~tready.
  - Empty-side stall: rd_wait & ~tvalid.
  - A handshake (tvalid & tready) is never a stall.
- Effective threshold: T = (thresh == 0) ? 1 : thresh. thresh is sampled every cycle; changing it mid-count compares the running counter against the new value.
- Per-channel FSM, active only while enable = 1:
  - IDLE: counter 0, block flag 0. stall & T==1 -> BLOCKED. stall & T>1 -> COUNT with counter 1. Otherwise stay.
  - COUNT: stall & (counter+1 >= T) -> BLOCKED. stall -> counter+1. ~stall -> IDLE with counter 0.
  - BLOCKED: block flag 1; counter holds at its value and never wraps. ~stall -> IDLE, and the flag drops on the same edge.
- Latency: after T consecutive stall cycles sampled on edges 1..T, axis_block_sigs[i] is high immediately after edge T. It falls on the first edge that samples ~stall.
- enable = 0: all channels are forced to IDLE on the next edge and block flags drop. Sticky diagnostics are kept.
- any_block is the registered OR of the next-state block flags, so it changes on the same edge as axis_block_sigs.
- first_block_vld / first_block_id:
  - On the first edge where any channel enters BLOCKED while first_block_vld = 0: set vld = 1 and capture the lowest index among the channels entering on that edge.
  - Both then hold until clear or reset.
- clear:
  - Zeros first_block_* and event_count.
  - If a channel enters BLOCKED on the same edge as clear, the new capture wins: vld = 1 with that id.
  - clear does not affect the FSMs.
- Reset mid-operation: all channels abort to IDLE on the next edge and every output returns to 0.

Optional Feature:
- Macro: HLS_STALL_STATS_EN.
- Defined: event_count increments by 1 on each rising edge of any_block (0->1), saturates at 0xFFFF, and is cleared by clear or reset. If a rise coincides with clear, the result is 1.
- Undefined: no counter logic is built; event_count is tied to 0.

Test Plan:
- NUM_CH=1, thresh=4, tvalid=1, tready=0 held from cycle 0 -> axis_block_sigs=1 and any_block=1 after edge 4, not after edge 3. first_block_vld=1, first_block_id=0.
- thresh=4, stall for 3 cycles, one handshake cycle, then stall for 3 more -> axis_block_sigs never asserts; the counter restarts at 1.
- NUM_CH=4, thresh=2, rd_wait=1 and tvalid=0 on ch2 and ch3 from the same cycle -> both flags rise after edge 2, first_block_id=2. Then tvalid[2]=1 -> flag 2 drops on the next edge while flag 3 stays high.
- Block ch0 with thresh=0 (behaves as 1) -> flag is high after edge 1. Pulse enable=0 for one cycle -> flag drops after that edge and re-asserts 1 cycle after enable returns. Sticky id is unchanged.
- HLS_STALL_STATS_EN defined: produce 3 separate block episodes -> event_count=3. Then clear -> event_count=0 and first_block_vld=0, while a still-active block flag stays 1.
- Assert reset for one cycle while ch1 is BLOCKED and first_block_vld=1 -> after that edge, all outputs are 0.

Source files
------------

// File: rtl/hls_axis_stall_detector.sv
// Per-channel AXI-stream stall detector: thresholded, registered block flags for the HLS deadlock monitor.
// Optional block-event counter is built when HLS_STALL_STATS_EN is defined; otherwise event_count is tied to 0.
module hls_axis_stall_detector #(
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 16,
    parameter int ID_W   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [CNT_W-1:0]  thresh,
    input  logic [NUM_CH-1:0] tvalid,
    input  logic [NUM_CH-1:0] tready,
    input  logic [NUM_CH-1:0] rd_wait,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              any_block,
    output logic              first_block_vld,
    output logic [ID_W-1:0]   first_block_id,
    output logic [15:0]       event_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] block_d;
    logic [NUM_CH-1:0] enter;
    logic [CNT_W-1:0]  t_eff;
    logic [ID_W-1:0]   enter_id;

    // True when one more stall cycle reaches the effective threshold.
    function automatic logic reach_thresh(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] t);
        reach_thresh = ({1'b0, c} + (CNT_W+1)'(1)) >= {1'b0, t};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
        sat_inc_cnt = (&c) ? c : c + CNT_W'(1);
    endfunction

    assign stall = (tvalid & ~tready) | (rd_wait & ~tvalid);
    assign t_eff = (thresh == '0) ? CNT_W'(1) : thresh;

    always_comb begin
        block_d = '0;
        enter   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!enable) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        cnt_d[i] = '0;
                        if (stall[i]) begin
                            if (t_eff == CNT_W'(1)) begin
                                state_d[i] = BLOCKED;
                                enter[i]   = 1'b1;
                            end else begin
                                state_d[i] = COUNT;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end
                    end
                    COUNT: begin
                        if (!stall[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = sat_inc_cnt(cnt_q[i]);
                            if (reach_thresh(cnt_q[i], t_eff)) begin
                                state_d[i] = BLOCKED;
                                enter[i]   = 1'b1;
                            end
                        end
                    end
                    BLOCKED: begin
                        // Counter is frozen while blocked so it can never wrap.
                        if (!stall[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            block_d[i] = (state_d[i] == BLOCKED);
        end
    end

    // Lowest-index channel entering BLOCKED on this edge.
    always_comb begin
        enter_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (enter[i]) begin
                enter_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            axis_block_sigs <= '0;
            any_block       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            axis_block_sigs <= block_d;
            any_block       <= |block_d;
        end
    end

    // A capture on the same edge as clear takes precedence over the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_block_vld <= 1'b0;
            first_block_id  <= '0;
        end else if ((|enter) && (!first_block_vld || clear)) begin
            first_block_vld <= 1'b1;
            first_block_id  <= enter_id;
        end else if (clear) begin
            first_block_vld <= 1'b0;
            first_block_id  <= '0;
        end
    end

`ifdef HLS_STALL_STATS_EN
    logic any_rise;

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        sat_inc16 = (&c) ? c : c + 16'd1;
    endfunction

    assign any_rise = (|block_d) & ~any_block;

    always_ff @(posedge clock) begin
        if (reset) begin
            event_count <= '0;
        end else if (clear) begin
            event_count <= any_rise ? 16'd1 : 16'd0;
        end else if (any_rise) begin
            event_count <= sat_inc16(event_count);
        end
    end
`else
    assign event_count = '0;
`endif

endmodule
